// File: rtl/matmul_result_drain_if.sv
// Result-BRAM read port and element stream bundle of the matmul result drain.
// The drain is the master: it drives the read request and the stream outputs.
interface matmul_result_drain_if #(
  parameter int DWIDTH  = 8,
  parameter int MAT_DIM = 4,
  parameter int AWIDTH  = 10
);
  logic                      bram_en;
  logic [AWIDTH-1:0]         bram_addr;
  logic [MAT_DIM*DWIDTH-1:0] bram_rdata;
  logic [DWIDTH-1:0]         m_data;
  logic                      m_valid;
  logic                      m_ready;
  logic                      m_last;

  modport master (
    output bram_en, bram_addr, m_data, m_valid, m_last,
    input  bram_rdata, m_ready
  );

  modport slave (
    input  bram_en, bram_addr, m_data, m_valid, m_last,
    output bram_rdata, m_ready
  );
endinterface

// File: rtl/matmul_result_drain.sv
// Drains the MAT_DIM x MAT_DIM result matrix row by row from the result BRAM
// and streams it element by element, then re-arms the multiplier via clear_done.
module matmul_result_drain #(
  parameter int DWIDTH    = 8,
  parameter int MAT_DIM   = 4,
  parameter int AWIDTH    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   done_mat_mul,
  output logic                   clear_done,
  output logic                   busy,
  matmul_result_drain_if.master  bus
);

  localparam int CW = (MAT_DIM > 1) ? $clog2(MAT_DIM) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(MAT_DIM - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    STREAM,
    CLEAR
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [CW-1:0]             row_cnt;
  logic [CW-1:0]             row_next;
  logic [CW-1:0]             col_cnt;
  logic [CW-1:0]             col_next;
  logic [MAT_DIM*DWIDTH-1:0] row_reg;
  logic [AWIDTH-1:0]         addr_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      row_cnt  <= '0;
      col_cnt  <= '0;
      row_reg  <= '0;
      addr_reg <= '0;
    end else begin
      state   <= state_next;
      row_cnt <= row_next;
      col_cnt <= col_next;
      if (state == CAPTURE) begin
        row_reg <= bus.bram_rdata;
      end
      // The address is loaded on entry to READ so it holds outside READ.
      if (state_next == READ) begin
        addr_reg <= AWIDTH'(BASE_ADDR) + AWIDTH'(row_next);
      end
    end
  end

  always_comb begin
    state_next = state;
    row_next   = row_cnt;
    col_next   = col_cnt;
    case (state)
      IDLE: begin
        if (done_mat_mul) begin
          row_next   = '0;
          state_next = READ;
        end
      end
      READ: begin
        state_next = CAPTURE;
      end
      CAPTURE: begin
        col_next   = '0;
        state_next = STREAM;
      end
      STREAM: begin
        if (bus.m_ready) begin
          col_next = col_cnt + 1'b1;
          if (col_cnt == LAST_IDX) begin
            if (row_cnt == LAST_IDX) begin
              state_next = CLEAR;
            end else begin
              row_next   = row_cnt + 1'b1;
              state_next = READ;
            end
          end
        end
      end
      CLEAR: begin
        if (!done_mat_mul) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.bram_en   = (state == READ);
  assign bus.bram_addr = addr_reg;
  assign bus.m_valid   = (state == STREAM);
  assign bus.m_data    = (state == STREAM) ? row_reg[col_cnt*DWIDTH +: DWIDTH] : '0;
  assign bus.m_last    = (state == STREAM) && (row_cnt == LAST_IDX) && (col_cnt == LAST_IDX);
  assign clear_done    = (state == CLEAR);
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_matmul_result_drain.sv
// Directed bench for matmul_result_drain: a 4x4 instance at BASE_ADDR 0 and a
// 2x2 instance at BASE_ADDR 8, each backed by a 1-cycle-latency BRAM model.
module tb_matmul_result_drain;

  typedef struct {
    int         row;
    int         col;
    logic [7:0] data;
    logic       last;
  } vec_t;

  logic clk;
  logic resetn;
  logic done_mat_mul;
  logic clear_done;
  logic busy;
  logic done2;
  logic clear2;
  logic busy2;

  int tests_run;
  int tests_failed;

  logic [31:0] mem  [0:1023];
  logic [15:0] mem2 [0:1023];
  vec_t        vecs [16];

  int          got_n;
  logic [7:0]  got_data [0:31];
  logic        got_last [0:31];
  int          first_valid;
  int          last_hs;
  int          clear_cycles;
  int          stall_errors;
  int          busy_after_drop;
  logic [9:0]  addr_log [$];

  matmul_result_drain_if #(.DWIDTH(8), .MAT_DIM(4), .AWIDTH(10)) bus ();
  matmul_result_drain_if #(.DWIDTH(8), .MAT_DIM(2), .AWIDTH(10)) bus2 ();

  matmul_result_drain #(.DWIDTH(8), .MAT_DIM(4), .AWIDTH(10), .BASE_ADDR(0)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .done_mat_mul (done_mat_mul),
    .clear_done   (clear_done),
    .busy         (busy),
    .bus          (bus.master)
  );

  matmul_result_drain #(.DWIDTH(8), .MAT_DIM(2), .AWIDTH(10), .BASE_ADDR(8)) dut2 (
    .clk          (clk),
    .resetn       (resetn),
    .done_mat_mul (done2),
    .clear_done   (clear2),
    .busy         (busy2),
    .bus          (bus2.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.bram_en) bus.bram_rdata <= mem[bus.bram_addr];
    if (bus2.bram_en) bus2.bram_rdata <= mem2[bus2.bram_addr];
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, ".clear_done"}, 32'(clear_done), 0);
    check_output({tag, ".bram_en"},    32'(bus.bram_en), 0);
    check_output({tag, ".bram_addr"},  32'(bus.bram_addr), 0);
    check_output({tag, ".m_data"},     32'(bus.m_data), 0);
    check_output({tag, ".m_valid"},    32'(bus.m_valid), 0);
    check_output({tag, ".m_last"},     32'(bus.m_last), 0);
    check_output({tag, ".busy"},       32'(busy), 0);
  endtask

  // One full drain on the 4x4 instance; cycle k is the k-th cycle after the
  // edge that first samples done_mat_mul high.
  task automatic apply_stimulus(input bit random_ready, input int hold_cycles);
    int k;
    int drop_k;
    bit ready;
    bit prev_stall;
    logic [7:0] prev_data;
    logic prev_last;
    got_n = 0; first_valid = -1; last_hs = -1; clear_cycles = 0;
    stall_errors = 0; busy_after_drop = 0; addr_log.delete();
    for (int i = 0; i < 32; i++) begin got_data[i] = 8'h00; got_last[i] = 1'b0; end
    drop_k = -1; prev_stall = 1'b0; prev_data = 8'h00; prev_last = 1'b0;
    @(negedge clk);
    done_mat_mul = 1'b1;
    bus.m_ready  = 1'b0;
    k = 0;
    while (k < 400) begin
      @(negedge clk);
      k++;
      if (bus.bram_en) addr_log.push_back(bus.bram_addr);
      if (clear_done) clear_cycles++;
      if (bus.m_valid && first_valid < 0) first_valid = k;
      if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data || bus.m_last !== prev_last))
        stall_errors++;
      if (drop_k >= 0 && k > drop_k && (busy || clear_done)) busy_after_drop++;
      if (drop_k >= 0 && k >= drop_k + 6) break;
      ready = random_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.m_ready = ready;
      if (bus.m_valid && ready) begin
        if (got_n < 32) begin
          got_data[got_n] = bus.m_data;
          got_last[got_n] = bus.m_last;
        end
        got_n++;
        if (bus.m_last) last_hs = k;
      end
      prev_stall = bus.m_valid && !ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
      if (last_hs >= 0 && drop_k < 0 && k == last_hs + hold_cycles) begin
        done_mat_mul = 1'b0;
        drop_k = k;
      end
    end
    bus.m_ready  = 1'b0;
    done_mat_mul = 1'b0;
    check_output("drain_timeout", 32'(k < 400), 1);
  endtask

  task automatic check_stream(input bit all_ones);
    logic [7:0] exp_data;
    logic       exp_last;
    check_output("elem_count", got_n, 16);
    for (int i = 0; i < 16; i++) begin
      exp_data = all_ones ? 8'h01 : vecs[i].data;
      exp_last = vecs[i].last;
      check_output($sformatf("data(%0d,%0d)", vecs[i].row, vecs[i].col), 32'(got_data[i]), 32'(exp_data));
      check_output($sformatf("last(%0d,%0d)", vecs[i].row, vecs[i].col), 32'(got_last[i]), 32'(exp_last));
    end
  endtask

  task automatic check_addrs();
    check_output("addr_count", addr_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("addr%0d", i), (i < addr_log.size()) ? 32'(addr_log[i]) : 32'hFFFF, i);
    end
  endtask

  task automatic load_basic();
    for (int i = 0; i < 1024; i++) begin mem[i] = 32'h0; mem2[i] = 16'h0; end
    mem[0] = 32'h22525A62;
    mem[1] = 32'h1A333F4B;
    mem[2] = 32'h132C303E;
    mem[3] = 32'h0D2E2836;
  endtask

  initial begin
    int hs;
    int k;
    bit saw_clear;
    int n2;
    int k2;
    int last2;
    logic [9:0] a2 [$];
    logic [7:0] d2 [4];

    tests_run = 0;
    tests_failed = 0;
    resetn = 1'b0;
    done_mat_mul = 1'b0;
    done2 = 1'b0;
    bus.m_ready = 1'b0;
    bus2.m_ready = 1'b0;

    vecs[0]  = '{0, 0, 8'h62, 1'b0}; vecs[1]  = '{0, 1, 8'h5A, 1'b0};
    vecs[2]  = '{0, 2, 8'h52, 1'b0}; vecs[3]  = '{0, 3, 8'h22, 1'b0};
    vecs[4]  = '{1, 0, 8'h4B, 1'b0}; vecs[5]  = '{1, 1, 8'h3F, 1'b0};
    vecs[6]  = '{1, 2, 8'h33, 1'b0}; vecs[7]  = '{1, 3, 8'h1A, 1'b0};
    vecs[8]  = '{2, 0, 8'h3E, 1'b0}; vecs[9]  = '{2, 1, 8'h30, 1'b0};
    vecs[10] = '{2, 2, 8'h2C, 1'b0}; vecs[11] = '{2, 3, 8'h13, 1'b0};
    vecs[12] = '{3, 0, 8'h36, 1'b0}; vecs[13] = '{3, 1, 8'h28, 1'b0};
    vecs[14] = '{3, 2, 8'h2E, 1'b0}; vecs[15] = '{3, 3, 8'h0D, 1'b1};
    load_basic();

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check_output("reset.busy2", 32'(busy2), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Basic drain with the sink always ready.
    apply_stimulus(1'b0, 1);
    check_stream(1'b0);
    check_addrs();
    check_output("first_valid_cycle", first_valid, 3);
    check_output("last_hs_cycle", last_hs, 24);
    check_output("basic.clear_cycles", clear_cycles, 1);
    check_output("basic.idle_after", busy_after_drop, 0);

    // Random backpressure.
    apply_stimulus(1'b1, 1);
    check_stream(1'b0);
    check_output("bp.stall_errors", stall_errors, 0);
    check_output("bp.clear_cycles", clear_cycles, 1);

    // done_mat_mul held for 5 cycles after the last element.
    apply_stimulus(1'b0, 5);
    check_stream(1'b0);
    check_output("hold.clear_cycles", clear_cycles, 5);
    check_output("hold.no_second_drain", busy_after_drop, 0);

    // Back-to-back job with new data.
    for (int i = 0; i < 4; i++) mem[i] = 32'h01010101;
    apply_stimulus(1'b0, 2);
    check_stream(1'b1);
    check_addrs();

    // Reset right after the 6th handshake.
    load_basic();
    hs = 0; k = 0; saw_clear = 1'b0;
    @(negedge clk);
    done_mat_mul = 1'b1;
    bus.m_ready = 1'b1;
    while (hs < 6 && k < 100) begin
      @(negedge clk);
      k++;
      if (clear_done) saw_clear = 1'b1;
      if (bus.m_valid && bus.m_ready) hs++;
    end
    check_output("abort.handshakes", hs, 6);
    @(negedge clk);
    resetn = 1'b0;
    done_mat_mul = 1'b0;
    bus.m_ready = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort");
    repeat (3) begin
      @(negedge clk);
      if (clear_done) saw_clear = 1'b1;
    end
    resetn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (clear_done) saw_clear = 1'b1;
    end
    check_output("abort.no_clear", 32'(saw_clear), 0);
    apply_stimulus(1'b0, 1);
    check_stream(1'b0);

    // 2x2 instance at BASE_ADDR 8.
    mem2[8] = 16'hBBAA;
    mem2[9] = 16'hDDCC;
    n2 = 0; k2 = 0; last2 = -1;
    for (int i = 0; i < 4; i++) d2[i] = 8'h00;
    @(negedge clk);
    done2 = 1'b1;
    bus2.m_ready = 1'b1;
    while (k2 < 60 && last2 < 0) begin
      @(negedge clk);
      k2++;
      if (bus2.bram_en) a2.push_back(bus2.bram_addr);
      if (bus2.m_valid) begin
        if (n2 < 4) d2[n2] = bus2.m_data;
        n2++;
        if (bus2.m_last) last2 = n2;
      end
    end
    done2 = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus2.bram_en) a2.push_back(bus2.bram_addr);
      if (bus2.m_valid) n2++;
    end
    check_output("dim2.count", n2, 4);
    check_output("dim2.last_index", last2, 4);
    check_output("dim2.last_cycle", k2, 8);
    check_output("dim2.addr_count", a2.size(), 2);
    check_output("dim2.addr0", (a2.size() > 0) ? 32'(a2[0]) : 32'hFFFF, 8);
    check_output("dim2.addr1", (a2.size() > 1) ? 32'(a2[1]) : 32'hFFFF, 9);
    check_output("dim2.d0", 32'(d2[0]), 32'hAA);
    check_output("dim2.d1", 32'(d2[1]), 32'hBB);
    check_output("dim2.d2", 32'(d2[2]), 32'hCC);
    check_output("dim2.d3", 32'(d2[3]), 32'hDD);
    check_output("dim2.idle", 32'(busy2), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
